// File: rtl/proj_pkg.sv
// Shared types and constants for the proj_counter block.
// The optional step prescaler is enabled by defining PROJ_PRESCALE_EN.
package proj_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = {CNT_W{1'b1}};
    localparam cnt_t CNT_MIN = '0;

    // Next-state selection for the count register.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } cnt_op_e;

    // Load has priority over any step.
    function automatic cnt_op_e sel_op(input logic ld, input logic en,
                                       input logic step, input logic up);
        cnt_op_e op;
        op = OP_HOLD;
        if (ld)
            op = OP_LOAD;
        else if (en && step)
            op = up ? OP_INC : OP_DEC;
        return op;
    endfunction

endpackage

// File: rtl/proj_prescaler.sv
// Step-strobe divider: pulses step once every PRESCALE enabled cycles.
// Only instantiated when PROJ_PRESCALE_EN is defined.
module proj_prescaler
    import proj_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;
    logic          at_last;

    assign at_last = (phase == LAST);

    // Phase only advances on enabled cycles, so en=0 freezes it mid-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= '0;
        else if (clr)
            phase <= '0;
        else if (en)
            phase <= at_last ? '0 : phase + PW'(1);
    end

    assign step = en && !clr && at_last;

endmodule

// File: rtl/proj_counter.sv
// Up/down counter with enable, parallel load and terminal-count flag.
// Define PROJ_PRESCALE_EN to advance only once every PRESCALE enabled cycles.
module proj_counter
    import proj_pkg::*;
#(
    parameter int WIDTH    = CNT_W,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TOP = {WIDTH{1'b1}};

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("proj_counter: PRESCALE must be >= 1");
    end

    logic             step;
    cnt_op_e          op;
    logic [WIDTH-1:0] cnt_nxt;

`ifdef PROJ_PRESCALE_EN
    proj_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (ld),
        .step  (step)
    );
`else
    assign step = 1'b1;
`endif

    assign op = sel_op(ld, en, step, up);

    // Wrap in both directions falls out of modulo-2^WIDTH arithmetic.
    always_comb begin
        cnt_nxt = cnt;
        case (op)
            OP_LOAD: cnt_nxt = d;
            OP_INC:  cnt_nxt = cnt + WIDTH'(1);
            OP_DEC:  cnt_nxt = cnt - WIDTH'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    assign tc = up ? (cnt == TOP) : (cnt == '0);

endmodule

// File: tb/tb_proj_counter.sv
// Directed self-checking bench for proj_counter; covers the prescaled
// variant as well when PROJ_PRESCALE_EN is defined.
module tb_proj_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] d;
    logic [3:0] cnt;
    logic       tc;

    int checks = 0;
    int errors = 0;

    proj_counter #(.WIDTH(4), .PRESCALE(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .up    (up),
        .ld    (ld),
        .d     (d),
        .cnt   (cnt),
        .tc    (tc)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp_cnt, input logic exp_tc);
        checks++;
        assert (cnt === exp_cnt) else begin
            errors++;
            $error("FAIL %s cnt=%0d expected=%0d", tag, cnt, exp_cnt);
        end
        checks++;
        assert (tc === exp_tc) else begin
            errors++;
            $error("FAIL %s tc=%0b expected=%0b", tag, tc, exp_tc);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; up = 1'b1; ld = 1'b0; d = 4'h0;
        #5;
        chk("reset_async", 4'd0, 1'b0);
        edge1();
        chk("reset_held", 4'd0, 1'b0);
        rst_n = 1'b1;

`ifdef PROJ_PRESCALE_EN
        // Prescaled: one step per 3 enabled edges, ld clears the phase.
        edge1(); chk("pre_e1", 4'd0, 1'b0);
        edge1(); chk("pre_e2", 4'd0, 1'b0);
        edge1(); chk("pre_e3", 4'd1, 1'b0);
        edge1(); chk("pre_e4", 4'd1, 1'b0);
        edge1(); chk("pre_e5", 4'd1, 1'b0);
        edge1(); chk("pre_e6", 4'd2, 1'b0);
        edge1(); chk("pre_e7", 4'd2, 1'b0);
        ld = 1'b1; d = 4'd5;
        edge1(); chk("pre_ld", 4'd5, 1'b0);
        ld = 1'b0;
        edge1(); chk("pre_ld_p1", 4'd5, 1'b0);
        en = 1'b0;
        edge1(); chk("pre_en0", 4'd5, 1'b0);
        en = 1'b1;
        edge1(); chk("pre_ld_p2", 4'd5, 1'b0);
        edge1(); chk("pre_ld_p3", 4'd6, 1'b0);
`else
        // Free-run through a full wrap.
        for (int i = 1; i <= 16; i++) begin
            edge1();
            chk("free_run", 4'(i % 16), (i == 15));
        end

        // Async reset mid-cycle at cnt=9.
        for (int i = 1; i <= 9; i++) edge1();
        chk("pre_reset_9", 4'd9, 1'b0);
        #4;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_cycle", 4'd0, 1'b0);
        edge1();
        chk("reset_mid_held", 4'd0, 1'b0);
        rst_n = 1'b1;
        edge1(); chk("resume_1", 4'd1, 1'b0);
        edge1(); chk("resume_2", 4'd2, 1'b0);

        // Down count through the 0 -> 15 wrap.
        up = 1'b0;
        #1; chk("down_tc_cnt2", 4'd2, 1'b0);
        edge1(); chk("down_1", 4'd1, 1'b0);
        edge1(); chk("down_0", 4'd0, 1'b1);
        edge1(); chk("down_15", 4'd15, 1'b0);
        edge1(); chk("down_14", 4'd14, 1'b0);

        // Load beats the 15 -> 0 wrap.
        up = 1'b1;
        edge1(); chk("up_15", 4'd15, 1'b1);
        ld = 1'b1; d = 4'hA;
        edge1(); chk("ld_prio", 4'd10, 1'b0);
        ld = 1'b0;
        edge1(); chk("ld_next", 4'd11, 1'b0);

        // Enable gating at 6.
        ld = 1'b1; d = 4'd6;
        edge1(); chk("ld_6", 4'd6, 1'b0);
        ld = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge1();
            chk("en_hold", 4'd6, 1'b0);
        end
        en = 1'b1;
        edge1(); chk("en_resume", 4'd7, 1'b0);

        // Load beats the down wrap, and works with en=0.
        up = 1'b0; ld = 1'b1; d = 4'd0; en = 1'b0;
        edge1(); chk("ld_en0", 4'd0, 1'b1);
        d = 4'd3; en = 1'b1;
        edge1(); chk("ld_prio_down", 4'd3, 1'b0);
        ld = 1'b0;
        edge1(); chk("down_after_ld", 4'd2, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
